bsg_fpu_class_gen: RTL
======================

// Module: bsg_fpu_class_gen
// PURPOSE
//  Inverse of the FP classifier: takes a 10-bit fclass-style one-hot/multi-hot class mask
//  and serially emits one representative FP value per set bit, lowest bit first.
//  Feeds FPU datapath test/stimulus and canonical-constant paths; every emitted z_o,
//  classified, yields exactly the class bit it was generated for.
// PARAMETERS
//  e_p      5    exponent width
//  m_p      10   mantissa width (m_p >= 2)
//  width_lp 1+e_p+m_p (local, not overridable); bias_lp = 2**(e_p-1)-1
// PORTS
//  clk_i      in   1         clock
//  reset_n_i  in   1         async active-low reset
//  v_i        in   1         request valid
//  class_i    in   10        class mask; bit order as classifier class_o[9:0]
//  payload_i  in   m_p       mantissa payload for normal/subnormal/NaN values
//  ready_o    in/out: out 1  can accept request (state IDLE)
//  v_o        out  1         z_o valid
//  z_o        out  width_lp  representative value {sign,exp,man}
//  class_o    out  10        one-hot: class bit z_o represents
//  last_o     out  1         current item is final set bit of the mask
//  yumi_i     in   1         consumer takes z_o; legal only when v_o=1
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; ready_o=1, v_o=0, z_o=0, class_o=0, last_o=0.
//  FSM IDLE/EMIT. ready_o = (state==IDLE); v_o = (state==EMIT); all outputs registered.
//  IDLE: v_i&ready_o accepts; latch class_i -> rem_r, payload_i -> pay_r.
//    class_i==0: request dropped, stay IDLE, v_o never asserts.
//    else -> EMIT next cycle; v_o=1 exactly one cycle after accept.
//  EMIT: class_o = lowest set bit of rem_r; last_o = (rem_r has one bit set).
//    z_o/class_o/last_o stable while v_o & ~yumi_i.
//    yumi_i: clear that bit; next item presented next cycle (1 item/cycle at full rate).
//    yumi_i on last item -> IDLE; ready_o=1 next cycle (no same-cycle re-accept).
//  v_i ignored outside IDLE; yumi_i with v_o=0 ignored (assertion fires).
//  Reset mid-EMIT: abort, pending bits discarded, outputs to reset values.
//  Value map (s=sign, E=all-ones exp, mnz = pay_r, or 1 if pay_r==0):
//    0 -inf   {1,E,0}            1 -normal {1,bias_lp,pay_r}   2 -subnorm {1,0,mnz}
//    3 -0     {1,0,0}            4 +0      {0,0,0}             5 +subnorm {0,0,mnz}
//    6 +normal{0,bias_lp,pay_r}  7 +inf    {0,E,0}
//    8 sNaN   {0,E,{1'b0,q}}, q = pay_r[m_p-2:0], or 1 if zero
//    9 qNaN   {0,E,{1'b1,pay_r[m_p-2:0]}}
// STRUCTURE
//  bsg_fpu_pkg: class index enum (neg_inf..q_nan = 0..9), FSM state typedef, fp16 constants.
//  Sub-module bsg_fpu_class_value: combinational (class one-hot, payload) -> z.
//  Lowest-set-bit pick via existing priority encoder; top = FSM + rem_r/pay_r regs.
// TESTING
//  1 class_i=10'h080, yumi_i=1 -> one beat z_o=16'h7C00, class_o=10'h080, last_o=1;
//    ready_o=1 two cycles after accept.
//  2 class_i=10'h3FF, payload_i=0, yumi_i=1 -> 10 beats: FC00,BC00,8001,8000,0000,0001,
//    3C00,7C00,7C01,7E00; last_o only on beat 10.
//  3 class_i=10'h042, payload_i=10'h155, yumi_i 0 for 3 cycles then 1 -> BD55 held 3 cycles,
//    then 3D55 with last_o=1.
//  4 class_i=10'h300, payload_i=10'h200 -> sNaN 7C01 (forced), qNaN 7E00.
//  5 class_i=0 with v_i=1 -> ready_o stays 1, v_o stays 0; second v_i while EMIT ignored.
//  6 reset_n_i low mid-EMIT of 10'h3FF after 4 beats -> v_o=0 at once; after release,
//    new class_i=10'h010 emits 0000 only.
//  All: scoreboard re-classifies every z_o; result must equal class_o.

Source files
------------

// File: rtl/bsg_fpu_pkg.sv
// Shared definitions for the FP class generator.
//   class_idx_e : bit positions of the fclass-style class mask (neg_inf .. q_nan)
//   state_e     : generator FSM states
//   fp16_*      : canonical half-precision constants
//   lowest_bit  : isolates the lowest set bit of a class mask (priority encoder)
package bsg_fpu_pkg;

    localparam int num_classes_gp = 10;

    typedef enum logic [3:0] {
        NEG_INF    = 4'd0,
        NEG_NORMAL = 4'd1,
        NEG_SUB    = 4'd2,
        NEG_ZERO   = 4'd3,
        POS_ZERO   = 4'd4,
        POS_SUB    = 4'd5,
        POS_NORMAL = 4'd6,
        POS_INF    = 4'd7,
        S_NAN      = 4'd8,
        Q_NAN      = 4'd9
    } class_idx_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [15:0] fp16_pos_inf  = 16'h7C00;
    localparam logic [15:0] fp16_neg_inf  = 16'hFC00;
    localparam logic [15:0] fp16_pos_one  = 16'h3C00;
    localparam logic [15:0] fp16_neg_one  = 16'hBC00;
    localparam logic [15:0] fp16_qnan     = 16'h7E00;

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    function automatic logic [num_classes_gp-1:0] lowest_bit(input logic [num_classes_gp-1:0] x);
        return x & (~x + num_classes_gp'(1));
    endfunction

endpackage

// File: rtl/bsg_fpu_class_value.sv
// Combinational map from a one-hot class select plus mantissa payload to a
// representative FP value of that class.
//   class_i   : one-hot class select (fclass bit order)
//   payload_i : mantissa payload used by normal/subnormal/NaN classes
//   z_o       : {sign, exponent, mantissa}; all zero when no class is selected
module bsg_fpu_class_value
    import bsg_fpu_pkg::*;
#(
    parameter int e_p = 5,
    parameter int m_p = 10
) (
    input  logic [num_classes_gp-1:0] class_i,
    input  logic [m_p-1:0]            payload_i,
    output logic [e_p+m_p:0]          z_o
);

    localparam logic [e_p-1:0] exp_ones = '1;
    localparam logic [e_p-1:0] bias_lp  = e_p'((1 << (e_p - 1)) - 1);

    logic [m_p-2:0] low;
    logic [m_p-1:0] mnz;
    logic [m_p-1:0] snan_man;

    assign low = payload_i[m_p-2:0];
    // Subnormals need a nonzero mantissa or they would classify as zero.
    assign mnz = (payload_i == '0) ? m_p'(1) : payload_i;
    // A signalling NaN with an all-zero payload would be infinity; force bit 0.
    assign snan_man = {1'b0, (low == '0) ? (m_p-1)'(1) : low};

    always_comb begin
        z_o = '0;
        if (class_i[NEG_INF])         z_o = {1'b1, exp_ones, {m_p{1'b0}}};
        else if (class_i[NEG_NORMAL]) z_o = {1'b1, bias_lp, payload_i};
        else if (class_i[NEG_SUB])    z_o = {1'b1, {e_p{1'b0}}, mnz};
        else if (class_i[NEG_ZERO])   z_o = {1'b1, {e_p{1'b0}}, {m_p{1'b0}}};
        else if (class_i[POS_ZERO])   z_o = '0;
        else if (class_i[POS_SUB])    z_o = {1'b0, {e_p{1'b0}}, mnz};
        else if (class_i[POS_NORMAL]) z_o = {1'b0, bias_lp, payload_i};
        else if (class_i[POS_INF])    z_o = {1'b0, exp_ones, {m_p{1'b0}}};
        else if (class_i[S_NAN])      z_o = {1'b0, exp_ones, snan_man};
        else if (class_i[Q_NAN])      z_o = {1'b0, exp_ones, 1'b1, low};
    end

endmodule

// File: rtl/bsg_fpu_class_gen.sv
// Serial FP class generator: accepts a class mask and emits one representative
// value per set bit, lowest bit first, over a valid/yumi handshake.
//   clk_i, reset_n_i     : clock, async active-low reset
//   v_i/ready_o          : request handshake (class_i, payload_i)
//   v_o/yumi_i           : output handshake (z_o, class_o, last_o)
//
// state | meaning
// IDLE  | waiting for a request; ready_o=1
// EMIT  | presenting the lowest remaining class bit; v_o=1
module bsg_fpu_class_gen
    import bsg_fpu_pkg::*;
#(
    parameter  int e_p      = 5,
    parameter  int m_p      = 10,
    localparam int width_lp = 1 + e_p + m_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [num_classes_gp-1:0] class_i,
    input  logic [m_p-1:0]            payload_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_lp-1:0]       z_o,
    output logic [num_classes_gp-1:0] class_o,
    output logic                      last_o,
    input  logic                      yumi_i
);

    state_e                      state_r, state_n;
    logic [num_classes_gp-1:0]   rem_r, rem_n;
    logic [m_p-1:0]              pay_r, pay_n;
    logic [num_classes_gp-1:0]   pick_n;
    logic                        last_n;
    logic [width_lp-1:0]         z_n;

    always_comb begin
        state_n = state_r;
        rem_n   = rem_r;
        pay_n   = pay_r;
        unique case (state_r)
            IDLE: begin
                if (v_i) begin
                    rem_n = class_i;
                    pay_n = payload_i;
                    if (class_i != '0) state_n = EMIT;
                end
            end
            EMIT: begin
                if (yumi_i) begin
                    rem_n = rem_r & (rem_r - num_classes_gp'(1));
                    if (rem_n == '0) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next-state remainder so they can be
    // registered and still show the new item in the cycle after accept/yumi.
    assign pick_n = lowest_bit(rem_n);
    assign last_n = (rem_n != '0) && ((rem_n & (rem_n - num_classes_gp'(1))) == '0);

    bsg_fpu_class_value #(.e_p(e_p), .m_p(m_p)) value_u (
        .class_i   (pick_n),
        .payload_i (pay_n),
        .z_o       (z_n)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            rem_r   <= '0;
            pay_r   <= '0;
            ready_o <= 1'b1;
            v_o     <= 1'b0;
            z_o     <= '0;
            class_o <= '0;
            last_o  <= 1'b0;
        end else begin
            state_r <= state_n;
            rem_r   <= rem_n;
            pay_r   <= pay_n;
            ready_o <= (state_n == IDLE);
            v_o     <= (state_n == EMIT);
            if (state_n == EMIT) begin
                z_o     <= z_n;
                class_o <= pick_n;
                last_o  <= last_n;
            end else begin
                z_o     <= '0;
                class_o <= '0;
                last_o  <= 1'b0;
            end
        end
    end

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");

endmodule
